// File: rtl/adder_bist_pkg.sv
// -----------------------------------------------------------------------------
// adder_bist_pkg
// Shared definitions for the exhaustive adder tester:
//   - ERR_W / ERR_MAX : width and saturation value of the mismatch counter
//   - state_e         : controller states (IDLE, APPLY, WAIT, CHECK, DONE)
//   - sat_inc()       : saturating increment used by the error counter
// -----------------------------------------------------------------------------
package adder_bist_pkg;

  localparam int unsigned     ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Increment that sticks at ERR_MAX instead of wrapping to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
    logic [ERR_W-1:0] result;
    if (value == ERR_MAX) begin
      result = value;
    end else begin
      result = value + ERR_W'(1'b1);
    end
    return result;
  endfunction

endpackage : adder_bist_pkg

// File: rtl/adder_bist_vec_gen.sv
// -----------------------------------------------------------------------------
// adder_bist_vec_gen
// Operand vector generator for the adder tester. Holds the vector index
// (2*WIDTH bits, a in the upper half, b in the lower half), clears or steps it
// on request, flags the last (all-ones) vector and registers the operands that
// are presented to the adder under test.
// Ports:
//   clk_i      clock, all state changes on the rising edge
//   reset_i    synchronous active-high reset (index and operands to 0)
//   clear_i    return the index to vector 0
//   incr_i     step to the next vector (never wraps past all-ones)
//   load_i     copy the current index into the operand registers
//   last_o     index is the all-ones vector
//   test_a_o   registered operand a
//   test_b_o   registered operand b
// -----------------------------------------------------------------------------
module adder_bist_vec_gen #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             incr_i,
  input  logic             load_i,
  output logic             last_o,
  output logic [WIDTH-1:0] test_a_o,
  output logic [WIDTH-1:0] test_b_o
);

  localparam int unsigned IDX_W = 2 * WIDTH;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             last_s;

  assign last_s = &idx_q;

  // Next index: clear has priority; the all-ones index holds so it cannot wrap.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (incr_i && !last_s) begin
      idx_d = idx_q + IDX_W'(1'b1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Operands are captured from the index only when asked, so they stay put
  // while the adder settles and is checked.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = idx_q[IDX_W-1:WIDTH];
      b_d = idx_q[WIDTH-1:0];
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
  end

  // Index and operand registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign last_o   = last_s;
  assign test_a_o = a_q;
  assign test_b_o = b_q;

endmodule : adder_bist_vec_gen

// File: rtl/adder_bist.sv
// -----------------------------------------------------------------------------
// adder_bist
// Exhaustive built-in tester for a combinational adder. Every (a,b) pair is
// driven in index order, the adder is given SETTLE idle cycles, then
// {dut_carry,dut_sum} is compared with a+b. Reports pass/fail, a saturating
// mismatch count and the operands of the first mismatch.
// Parameters:
//   WIDTH         operand width; 2^(2*WIDTH) vectors per run
//   SETTLE        idle cycles between driving and sampling (0 allowed)
//   STOP_ON_FAIL  non-zero: end the run at the first mismatch
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse, honoured only from IDLE or DONE
//   test_a/b   registered operands to the adder under test
//   dut_sum    adder sum, sampled only in CHECK
//   dut_carry  adder carry, sampled only in CHECK
//   busy       run in progress
//   done       run finished, held until the next start or reset
//   pass       run finished with no mismatch
//   err_count  mismatch count, saturating at 255
//   fail_a/b   operands of the first mismatch (0 if none)
// -----------------------------------------------------------------------------
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned SETTLE       = 1,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] test_a,
  output logic [WIDTH-1:0] test_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  // Settle counter runs SETTLE-1 down to 0; keep at least one bit so the
  // SETTLE=0 and SETTLE=1 builds still elaborate.
  localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;

  logic             clear_s;
  logic             incr_s;
  logic             load_s;
  logic             last_s;
  logic [WIDTH:0]   expected_s;
  logic [WIDTH:0]   observed_s;
  logic             mismatch_s;

  adder_bist_vec_gen #(
    .WIDTH (WIDTH)
  ) u_vec_gen (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (clear_s),
    .incr_i   (incr_s),
    .load_i   (load_s),
    .last_o   (last_s),
    .test_a_o (test_a),
    .test_b_o (test_b)
  );

  // Reference sum is formed from the registered operands the adder is seeing,
  // so the compare is exact regardless of which vector index is current.
  assign expected_s = {1'b0, test_a} + {1'b0, test_b};
  assign observed_s = {dut_carry, dut_sum};
  assign mismatch_s = (observed_s != expected_s);

  // Controller: next state, vector-generator controls and result updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    clear_s  = 1'b0;
    incr_s   = 1'b0;
    load_s   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_APPLY;
          clear_s  = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
        end else begin
          state_d = state_q;
        end
      end

      ST_APPLY: begin
        load_s = 1'b1;
        if (SETTLE > 0) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1'b1);
        end
      end

      ST_CHECK: begin
        if (mismatch_s) begin
          err_d = sat_inc(err_q);
          // The counter only leaves zero on a mismatch, so zero here means
          // this is the first one of the run.
          if (err_q == '0) begin
            fail_a_d = test_a;
            fail_b_d = test_b;
          end else begin
            fail_a_d = fail_a_q;
            fail_b_d = fail_b_q;
          end
        end else begin
          err_d = err_q;
        end

        if (last_s || ((STOP_ON_FAIL != 0) && mismatch_s)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_APPLY;
          incr_s  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule : adder_bist
